// File: rtl/matrix_operand_loader_if.sv
//==============================================================================
// Module   : matrix_operand_loader_if
// Purpose  : Bundles the element stream (in_*) and the packed operand output
//            (mat_*, load_cnt) of matrix_operand_loader.
// Ports    : slave modport  - used by the loader (consumes the stream,
//                             drives the operand buses)
//            master modport - used by the producer/consumer environment
//            in_abort exists only when MATRIX_LOADER_ABORT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface matrix_operand_loader_if #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 9
);
    logic [ELEM_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [ELEM_W*N_ELEM-1:0] mat_a;
    logic [ELEM_W*N_ELEM-1:0] mat_b;
    logic                     mat_valid;
    logic                     mat_ack;
    logic [4:0]               load_cnt;

`ifdef MATRIX_LOADER_ABORT_EN
    logic                     in_abort;

    modport slave (
        input  in_data, in_valid, mat_ack, in_abort,
        output in_ready, mat_a, mat_b, mat_valid, load_cnt
    );

    modport master (
        output in_data, in_valid, mat_ack, in_abort,
        input  in_ready, mat_a, mat_b, mat_valid, load_cnt
    );
`else
    modport slave (
        input  in_data, in_valid, mat_ack,
        output in_ready, mat_a, mat_b, mat_valid, load_cnt
    );

    modport master (
        output in_data, in_valid, mat_ack,
        input  in_ready, mat_a, mat_b, mat_valid, load_cnt
    );
`endif

endinterface

`default_nettype wire

// File: rtl/matrix_operand_loader.sv
//==============================================================================
// Module   : matrix_operand_loader
// Purpose  : Collects 2*N_ELEM words from a valid/ready stream (A[0..8] then
//            B[0..8], row-major) into two flat operand buses and holds them
//            with mat_valid high until the consumer acknowledges.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - matrix_operand_loader_if.slave (in_data/in_valid/in_ready,
//                   mat_a/mat_b/mat_valid/mat_ack, load_cnt[, in_abort])
// Config   : MATRIX_LOADER_ABORT_EN - adds in_abort, which cancels a partial
//            frame while loading (buses keep their contents).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_operand_loader #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 9
) (
    input  wire logic                clk,
    input  wire logic                rst,
    matrix_operand_loader_if.slave   bus
);

    localparam int                c_IDX_W       = $clog2(N_ELEM);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(N_ELEM - 1);
    localparam logic [4:0]        c_FRAME_WORDS = 5'(2 * N_ELEM);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [c_IDX_W-1:0]        r_idx;
    logic [4:0]                r_cnt;
    logic [ELEM_W*N_ELEM-1:0]  r_mat_a;
    logic [ELEM_W*N_ELEM-1:0]  r_mat_b;
    logic                      r_in_ready;
    logic                      r_mat_valid;
    logic                      w_abort;

`ifdef MATRIX_LOADER_ABORT_EN
    assign w_abort = bus.in_abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD_A;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_in_ready  <= 1'b0;
            r_mat_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A, LOAD_B: begin
                    // in_ready is held low during reset; the first edge after
                    // release raises it, so beats only count once it is high.
                    r_in_ready <= 1'b1;
                    if (w_abort) begin
                        // Abort wins over a same-cycle beat: the word is dropped.
                        r_state <= LOAD_A;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end else if (bus.in_valid && r_in_ready) begin
                        for (int k = 0; k < N_ELEM; k++) begin
                            if (r_idx == c_IDX_W'(k)) begin
                                if (r_state == LOAD_A)
                                    r_mat_a[k*ELEM_W +: ELEM_W] <= bus.in_data;
                                else
                                    r_mat_b[k*ELEM_W +: ELEM_W] <= bus.in_data;
                            end
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
                            if (r_state == LOAD_A) begin
                                r_state <= LOAD_B;
                            end else begin
                                r_state     <= HOLD;
                                r_in_ready  <= 1'b0;
                                r_mat_valid <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    // Buses frozen; only the acknowledge moves us on.
                    if (bus.mat_ack) begin
                        r_state     <= LOAD_A;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_mat_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_cnt <= c_FRAME_WORDS;
                    end
                end

                default: begin
                    r_state     <= LOAD_A;
                    r_idx       <= '0;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b0;
                    r_mat_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mat_valid = r_mat_valid;
    assign bus.mat_a     = r_mat_a;
    assign bus.mat_b     = r_mat_b;
    assign bus.load_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
//==============================================================================
// Module   : tb_matrix_operand_loader
// Purpose  : Self-checking bench for matrix_operand_loader. A word-list model
//            (words accepted so far in the frame, plus retained A/B arrays)
//            predicts ready/valid/count/bus contents each cycle.
// Config   : MATRIX_LOADER_ABORT_EN enables the abort scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_matrix_operand_loader;

    localparam int c_FRAME = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    matrix_operand_loader_if #(.ELEM_W(16), .N_ELEM(9)) bus ();

    matrix_operand_loader #(.ELEM_W(16), .N_ELEM(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: m_n words accepted in the current frame; matrices
    // retain old elements until overwritten.
    logic [15:0] m_a [9];
    logic [15:0] m_b [9];
    int          m_n;
    logic        m_rdy;

    function automatic logic [143:0] pack(input logic [15:0] e [9]);
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[k*16 +: 16] = e[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            m_a[k] = '0;
            m_b[k] = '0;
        end
        m_n   = 0;
        m_rdy = 1'b0;
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance model at the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic ack,
                         input logic ab);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.mat_ack  = ack;
`ifdef MATRIX_LOADER_ABORT_EN
        bus.in_abort = ab;
`endif
        @(posedge clk);
`ifdef MATRIX_LOADER_ABORT_EN
        if (ab && m_n < c_FRAME) begin
            m_n   = 0;
            m_rdy = 1'b1;
        end else
`endif
        if (m_n == c_FRAME) begin
            if (ack) m_n = 0;
        end else if (m_rdy && v) begin
            if (m_n < 9) m_a[m_n] = d;
            else         m_b[m_n-9] = d;
            m_n++;
        end
        m_rdy = (m_n < c_FRAME);
        #1;
        bus.in_valid = 1'b0;
        bus.mat_ack  = 1'b0;
`ifdef MATRIX_LOADER_ABORT_EN
        bus.in_abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (3) cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        // model saw beats with m_rdy=0 only after reset; re-clear it
        model_reset();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.mat_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.mat_valid); end
        total++; if (bus.load_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.load_cnt); end
        total++; if (bus.mat_a !== 144'd0 || bus.mat_b !== 144'd0) begin bad++; $display("FAIL reset_bus: a=%h b=%h want 0", bus.mat_a, bus.mat_b); end
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < c_FRAME; k++) begin
            cycle(1'b1, 16'(k + 1), 1'b0, 1'b0);
            total++; if (bus.load_cnt !== 5'(m_n)) begin bad++; $display("FAIL full_cnt[%0d]: got %0d want %0d", k, bus.load_cnt, m_n); end
        end
        total++; if (bus.mat_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1", bus.mat_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.load_cnt !== 5'd18) begin bad++; $display("FAIL full_cnt18: got %0d want 18", bus.load_cnt); end
        for (int k = 0; k < 9; k++) begin
            total++; if (bus.mat_a[k*16 +: 16] !== 16'(k + 1)) begin bad++; $display("FAIL full_a[%0d]: got %h want %h", k, bus.mat_a[k*16 +: 16], 16'(k + 1)); end
            total++; if (bus.mat_b[k*16 +: 16] !== 16'(k + 10)) begin bad++; $display("FAIL full_b[%0d]: got %h want %h", k, bus.mat_b[k*16 +: 16], 16'(k + 10)); end
        end
    endtask

    task automatic test_hold_ignore();
        logic [143:0] a0, b0;
        a0 = pack(m_a);
        b0 = pack(m_b);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
            total++; if (bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b1) begin bad++; $display("FAIL hold_flags[%0d]: ready=%b valid=%b want 0/1", k, bus.in_ready, bus.mat_valid); end
            total++; if (bus.mat_a !== a0 || bus.mat_b !== b0) begin bad++; $display("FAIL hold_bus[%0d]: a=%h b=%h want a=%h b=%h", k, bus.mat_a, bus.mat_b, a0, b0); end
            total++; if (bus.load_cnt !== 5'd18) begin bad++; $display("FAIL hold_cnt[%0d]: got %0d want 18", k, bus.load_cnt); end
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        total++; if (bus.mat_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_ack: valid=%b ready=%b want 0/1", bus.mat_valid, bus.in_ready); end
        total++; if (bus.load_cnt !== 5'd0) begin bad++; $display("FAIL hold_ack_cnt: got %0d want 0", bus.load_cnt); end
    endtask

    task automatic test_toggle_valid();
        int cyc = 0;
        while (m_n < c_FRAME && cyc < 100) begin
            cycle(cyc[0] == 1'b0, 16'($urandom), 1'b0, 1'b0);
            cyc++;
            total++; if (bus.load_cnt !== 5'(m_n)) begin bad++; $display("FAIL toggle_cnt[%0d]: got %0d want %0d", cyc, bus.load_cnt, m_n); end
        end
        total++; if (m_n != c_FRAME) begin bad++; $display("FAIL toggle_timeout: beats %0d want 18", m_n); end
        total++; if (bus.mat_valid !== 1'b1) begin bad++; $display("FAIL toggle_valid: got %b want 1", bus.mat_valid); end
        total++; if (bus.mat_a !== pack(m_a) || bus.mat_b !== pack(m_b)) begin bad++; $display("FAIL toggle_bus: a=%h b=%h want a=%h b=%h", bus.mat_a, bus.mat_b, pack(m_a), pack(m_b)); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_ack_in_load();
        for (int k = 0; k < 4; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
        total++; if (bus.load_cnt !== 5'd5 || bus.mat_valid !== 1'b0) begin bad++; $display("FAIL ack_in_load: cnt=%0d valid=%b want 5/0", bus.load_cnt, bus.mat_valid); end
        while (m_n < c_FRAME) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        total++; if (bus.mat_a !== pack(m_a) || bus.mat_b !== pack(m_b)) begin bad++; $display("FAIL ack_frame_bus: a=%h b=%h want a=%h b=%h", bus.mat_a, bus.mat_b, pack(m_a), pack(m_b)); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 11; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++; if (bus.mat_a !== 144'd0 || bus.mat_b !== 144'd0) begin bad++; $display("FAIL async_bus: a=%h b=%h want 0", bus.mat_a, bus.mat_b); end
        total++; if (bus.load_cnt !== 5'd0 || bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b0) begin bad++; $display("FAIL async_ctrl: cnt=%0d ready=%b valid=%b want 0", bus.load_cnt, bus.in_ready, bus.mat_valid); end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
        total++; if (bus.load_cnt !== 5'd0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL async_release: cnt=%0d ready=%b want 0/1", bus.load_cnt, bus.in_ready); end
        while (m_n < c_FRAME) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        total++; if (bus.mat_a !== pack(m_a) || bus.mat_b !== pack(m_b) || bus.mat_valid !== 1'b1) begin bad++; $display("FAIL async_frame: a=%h b=%h want a=%h b=%h", bus.mat_a, bus.mat_b, pack(m_a), pack(m_b)); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            int cyc = 0;
            while (m_n < c_FRAME && cyc < 200) begin
                cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, 1'b0);
                cyc++;
            end
            total++; if (bus.mat_valid !== 1'b1 || bus.load_cnt !== 5'd18) begin bad++; $display("FAIL b2b_done[%0d]: valid=%b cnt=%0d want 1/18", f, bus.mat_valid, bus.load_cnt); end
            total++; if (bus.mat_a !== pack(m_a) || bus.mat_b !== pack(m_b)) begin bad++; $display("FAIL b2b_bus[%0d]: a=%h b=%h want a=%h b=%h", f, bus.mat_a, bus.mat_b, pack(m_a), pack(m_b)); end
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0);
            total++; if (bus.in_ready !== 1'b1 || bus.load_cnt !== 5'd0) begin bad++; $display("FAIL b2b_ack[%0d]: ready=%b cnt=%0d want 1/0", f, bus.in_ready, bus.load_cnt); end
        end
    endtask

`ifdef MATRIX_LOADER_ABORT_EN
    task automatic test_abort();
        for (int k = 0; k < 12; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
        total++; if (bus.load_cnt !== 5'd0 || bus.in_ready !== 1'b1 || bus.mat_valid !== 1'b0) begin bad++; $display("FAIL abort_state: cnt=%0d ready=%b valid=%b want 0/1/0", bus.load_cnt, bus.in_ready, bus.mat_valid); end
        total++; if (bus.mat_b[3*16 +: 16] === 16'hDEAD) begin bad++; $display("FAIL abort_drop: b[3]=%h should not be DEAD", bus.mat_b[3*16 +: 16]); end
        while (m_n < c_FRAME) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        total++; if (bus.mat_a !== pack(m_a) || bus.mat_b !== pack(m_b)) begin bad++; $display("FAIL abort_frame: a=%h b=%h want a=%h b=%h", bus.mat_a, bus.mat_b, pack(m_a), pack(m_b)); end
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        total++; if (bus.mat_valid !== 1'b1 || bus.load_cnt !== 5'd18) begin bad++; $display("FAIL abort_in_hold: valid=%b cnt=%0d want 1/18", bus.mat_valid, bus.load_cnt); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mat_ack  = 1'b0;
`ifdef MATRIX_LOADER_ABORT_EN
        bus.in_abort = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_full_frame();
        test_hold_ignore();
        test_toggle_valid();
        test_ack_in_load();
        test_async_reset();
        test_back_to_back();
`ifdef MATRIX_LOADER_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
